// File: rtl/router_xy_rr.sv
// 3-port XY mesh router tile: per-input FIFOs, dimension-order routing, per-output round-robin.
// Optional per-output flit counters are built when ROUTER_STATS_EN is defined.
module router_xy_rr #(
    parameter int unsigned WD    = 40,
    parameter int unsigned AW    = 3,
    parameter int unsigned CW    = 1,
    parameter int unsigned CUR_X = 0,
    parameter int unsigned CUR_Y = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      in_valid,
    input  logic [3*WD-1:0] in_data,
    output logic [2:0]      in_full,
    input  logic [2:0]      next_full,
    output logic [2:0]      out_valid,
    output logic [3*WD-1:0] out_data
`ifdef ROUTER_STATS_EN
    ,
    output logic [3*CNT_W-1:0] flit_cnt
`endif
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [CW-1:0] CurX = CW'(CUR_X);
    localparam logic [CW-1:0] CurY = CW'(CUR_Y);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    if (WD < 2 * CW + 1 || CNT_W < 1) begin : g_param_check
        $error("router_xy_rr: WD must be >= 2*CW+1 and CNT_W >= 1");
    end

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    logic [WD-1:0] mem_q    [3][DEPTH];
    logic [AW-1:0] wr_ptr_q [3];
    logic [AW-1:0] rd_ptr_q [3];
    logic [AW:0]   count_q  [3];
    logic [AW:0]   count_d  [3];
    logic [1:0]    rr_ptr_q [3];
    logic [2:0]    out_valid_q;
    logic [3*WD-1:0] out_data_q;

    logic [WD-1:0] head      [3];
    logic [1:0]    dest      [3];
    logic [1:0]    grant_idx [3];
    logic [2:0]    empty;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic [2:0]    grant;
    logic [1:0]    cand;

    // FIFO status and X-then-Y route decision on each head flit.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            head[p]    = mem_q[p][rd_ptr_q[p]];
            empty[p]   = (count_q[p] == '0);
            in_full[p] = (count_q[p] == FullCount);
            push[p]    = in_valid[p] && !in_full[p];
            if (head[p][WD-1 -: CW] != CurX) begin
                dest[p] = 2'd1;
            end else if (head[p][WD-1-CW -: CW] != CurY) begin
                dest[p] = 2'd2;
            end else begin
                dest[p] = 2'd0;
            end
        end
    end

    // Round-robin scan from rr_ptr_q; a full downstream FIFO blocks only its own output.
    always_comb begin
        grant = '0;
        pop   = '0;
        cand  = '0;
        for (int o = 0; o < 3; o++) begin
            grant_idx[o] = rr_ptr_q[o];
            cand         = rr_ptr_q[o];
            for (int k = 0; k < 3; k++) begin
                if (!grant[o] && !next_full[o] && !empty[cand] && dest[cand] == 2'(o)) begin
                    grant[o]     = 1'b1;
                    grant_idx[o] = cand;
                end
                cand = inc3(cand);
            end
        end
        for (int o = 0; o < 3; o++) begin
            if (grant[o]) begin
                pop[grant_idx[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            case ({push[p], pop[p]})
                2'b10:   count_d[p] = count_q[p] + 1'b1;
                2'b01:   count_d[p] = count_q[p] - 1'b1;
                default: count_d[p] = count_q[p];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (push[p]) begin
                    wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
                end
                count_q[p] <= count_d[p];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counts alone.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (push[p]) begin
                mem_q[p][wr_ptr_q[p]] <= in_data[p*WD +: WD];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            for (int o = 0; o < 3; o++) begin
                rr_ptr_q[o] <= '0;
            end
        end else begin
            out_valid_q <= grant;
            for (int o = 0; o < 3; o++) begin
                if (grant[o]) begin
                    out_data_q[o*WD +: WD] <= head[grant_idx[o]];
                    rr_ptr_q[o]            <= inc3(grant_idx[o]);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef ROUTER_STATS_EN
    logic [CNT_W-1:0] cnt_q [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < 3; o++) begin
                cnt_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (out_valid_q[o]) begin
                    cnt_q[o] <= cnt_q[o] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            flit_cnt[o*CNT_W +: CNT_W] = cnt_q[o];
        end
    end
`endif

endmodule
